rob_alloc_tracker: RTL and testbench

- Decode-side initiator for the reorder buffer's allocate/commit protocol.
- Owns the ROB tail pointer and occupancy count, and issues allocation index and full status to decode and the ROB.
- Keeps a per-architectural-register scoreboard of in-flight producer ROB tags, so decode knows which sources are still pending.
- Consumes commit and nuke events from the ROB so it stays in lockstep with the ROB head.

---
 rtl/rob_alloc_tracker.sv | 130 +++++++++++++
 tb/tb_rob_alloc_tracker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc_tracker.sv
// Decode-side ROB allocation tracker: owns the tail pointer and occupancy count, and keeps a
// per-register scoreboard of in-flight producer tags that follows ROB commits and nukes.
module rob_alloc_tracker #(
    parameter int ROB_SIZE = 10,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 4,
    parameter int NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_alloc_req,
    input  logic             in_stall,
    input  logic [4:0]       in_alloc_rd,
    input  logic             in_alloc_writes_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic             in_commit,
    input  logic [IDX_W-1:0] in_commit_idx,
    input  logic             in_nuke,
    output logic             out_alloc,
    output logic [IDX_W-1:0] out_alloc_idx,
    output logic             out_full,
    output logic             out_empty,
    output logic [CNT_W-1:0] out_count,
    output logic             out_rs1_pending,
    output logic [IDX_W-1:0] out_rs1_tag,
    output logic             out_rs2_pending,
    output logic [IDX_W-1:0] out_rs2_tag,
    output logic             out_order_err
);

    logic [IDX_W-1:0]    head;
    logic [IDX_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [NUM_REGS-1:0] pend;
    logic [IDX_W-1:0]    tag [NUM_REGS];
    logic                err;

    logic                fire;
    logic                commit_req;
    logic                legal_commit;
    logic                illegal_commit;
    logic [NUM_REGS-1:0] alloc_hit;
    logic [NUM_REGS-1:0] commit_hit;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(ROB_SIZE - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    // Allocation handshake: in_alloc_req is valid, (!out_full & !in_stall & !in_nuke) is ready;
    // an entry transfers (out_alloc=1) only when both are high, and the entry handed over in
    // that cycle is out_alloc_idx. Full is taken from the registered count, so a same-cycle
    // commit never opens a slot for the current request.
    assign out_full       = (count == CNT_W'(ROB_SIZE));
    assign out_empty      = (count == '0);
    assign fire           = in_alloc_req & ~in_stall & ~out_full & ~in_nuke;
    assign commit_req     = in_commit & ~in_nuke;
    assign legal_commit   = commit_req & ~out_empty & (in_commit_idx == head);
    assign illegal_commit = commit_req & ~legal_commit;

    assign out_alloc      = fire;
    assign out_alloc_idx  = tail;
    assign out_count      = count;
    assign out_order_err  = err;

    always_comb begin
        alloc_hit = '0;
        if (fire && in_alloc_writes_rd && (in_alloc_rd != '0))
            alloc_hit[in_alloc_rd] = 1'b1;
    end

    // Commit matches use the pre-update tags, so a same-cycle re-allocation of rd survives.
    always_comb begin
        commit_hit = '0;
        for (int r = 0; r < NUM_REGS; r++)
            commit_hit[r] = legal_commit & pend[r] & (tag[r] == in_commit_idx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (illegal_commit)
                err <= 1'b1;
            if (in_nuke) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (fire)
                    tail <= wrap_inc(tail);
                if (legal_commit)
                    head <= wrap_inc(head);
                count <= count + CNT_W'(fire) - CNT_W'(legal_commit);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            for (int r = 0; r < NUM_REGS; r++)
                tag[r] <= '0;
        end else if (in_nuke) begin
            pend <= '0;
            for (int r = 0; r < NUM_REGS; r++)
                tag[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (alloc_hit[r]) begin
                    pend[r] <= 1'b1;
                    tag[r]  <= tail;
                end else if (commit_hit[r]) begin
                    pend[r] <= 1'b0;
                    tag[r]  <= '0;
                end
            end
        end
    end

    // x0 is never set in pend, but the explicit check keeps the lookup independent of that.
    assign out_rs1_pending = (in_rs1 != '0) & pend[in_rs1];
    assign out_rs1_tag     = out_rs1_pending ? tag[in_rs1] : '0;
    assign out_rs2_pending = (in_rs2 != '0) & pend[in_rs2];
    assign out_rs2_tag     = out_rs2_pending ? tag[in_rs2] : '0;

endmodule

// File: tb/tb_rob_alloc_tracker.sv
// Bench for rob_alloc_tracker: a table of per-cycle vectors with hand-derived expected
// outputs, pushed to an expected queue at drive time and popped when the outputs settle.
module tb_rob_alloc_tracker;

    localparam int IDX_W = 4;
    localparam int CNT_W = 4;
    localparam int EXP_W = 22;

    logic             clk;
    logic             reset;
    logic             in_alloc_req;
    logic             in_stall;
    logic [4:0]       in_alloc_rd;
    logic             in_alloc_writes_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic             in_commit;
    logic [IDX_W-1:0] in_commit_idx;
    logic             in_nuke;
    logic             out_alloc;
    logic [IDX_W-1:0] out_alloc_idx;
    logic             out_full;
    logic             out_empty;
    logic [CNT_W-1:0] out_count;
    logic             out_rs1_pending;
    logic [IDX_W-1:0] out_rs1_tag;
    logic             out_rs2_pending;
    logic [IDX_W-1:0] out_rs2_tag;
    logic             out_order_err;

    rob_alloc_tracker #(
        .ROB_SIZE(10), .IDX_W(IDX_W), .CNT_W(CNT_W), .NUM_REGS(32)
    ) dut (
        .clk(clk), .reset(reset),
        .in_alloc_req(in_alloc_req), .in_stall(in_stall),
        .in_alloc_rd(in_alloc_rd), .in_alloc_writes_rd(in_alloc_writes_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_commit(in_commit), .in_commit_idx(in_commit_idx), .in_nuke(in_nuke),
        .out_alloc(out_alloc), .out_alloc_idx(out_alloc_idx),
        .out_full(out_full), .out_empty(out_empty), .out_count(out_count),
        .out_rs1_pending(out_rs1_pending), .out_rs1_tag(out_rs1_tag),
        .out_rs2_pending(out_rs2_pending), .out_rs2_tag(out_rs2_tag),
        .out_order_err(out_order_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             req;
        logic             stall;
        logic [4:0]       rd;
        logic             wr;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic             com;
        logic [IDX_W-1:0] cidx;
        logic             nuke;
        logic [EXP_W-1:0] exp;
    } vec_t;

    vec_t             vecs[$];
    logic [EXP_W-1:0] exp_q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    // expected word: alloc, idx, full, empty, count, p1, t1, p2, t2, err
    function automatic logic [EXP_W-1:0] pack_exp(input int ea, input int ei, input int ef,
        input int ee, input int ec, input int ep1, input int et1, input int ep2,
        input int et2, input int er);
        return {1'(ea), 4'(ei), 1'(ef), 1'(ee), 4'(ec), 1'(ep1), 4'(et1), 1'(ep2), 4'(et2), 1'(er)};
    endfunction

    function automatic vec_t mk(input int req, input int stall, input int rd, input int wr,
        input int rs1, input int rs2, input int com, input int cidx, input int nuke,
        input int ea, input int ei, input int ef, input int ee, input int ec,
        input int ep1, input int et1, input int ep2, input int et2, input int er);
        vec_t v;
        v.req   = 1'(req);
        v.stall = 1'(stall);
        v.rd    = 5'(rd);
        v.wr    = 1'(wr);
        v.rs1   = 5'(rs1);
        v.rs2   = 5'(rs2);
        v.com   = 1'(com);
        v.cidx  = 4'(cidx);
        v.nuke  = 1'(nuke);
        v.exp   = pack_exp(ea, ei, ef, ee, ec, ep1, et1, ep2, et2, er);
        return v;
    endfunction

    // driver tasks
    task automatic drive(input vec_t v);
        in_alloc_req       = v.req;
        in_stall           = v.stall;
        in_alloc_rd        = v.rd;
        in_alloc_writes_rd = v.wr;
        in_rs1             = v.rs1;
        in_rs2             = v.rs2;
        in_commit          = v.com;
        in_commit_idx      = v.cidx;
        in_nuke            = v.nuke;
    endtask

    // scoreboard
    task automatic check(input string name);
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] want;
        got = {out_alloc, out_alloc_idx, out_full, out_empty, out_count,
               out_rs1_pending, out_rs1_tag, out_rs2_pending, out_rs2_tag, out_order_err};
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: expected queue empty, got=%h", name, got);
            return;
        end
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got alloc=%0d idx=%0d full=%0d empty=%0d cnt=%0d p1=%0d t1=%0d p2=%0d t2=%0d err=%0d, required %h (got %h)",
                     name, out_alloc, out_alloc_idx, out_full, out_empty, out_count,
                     out_rs1_pending, out_rs1_tag, out_rs2_pending, out_rs2_tag,
                     out_order_err, want, got);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        check(name);
    endtask

    initial begin
        // stall blocks a request straight out of reset
        vecs.push_back(mk(1,1,1,1, 0,0, 0,0,0,  0,0,0,1,0, 0,0,0,0, 0));
        // ten fires, rs1 looks at the previous rd, rs2 at own rd (never visible)
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1,0,i+1,1, i,i+1, 0,0,0,
                              1,i,0,(i == 0) ? 1 : 0,i, (i >= 1) ? 1 : 0,(i >= 1) ? i-1 : 0,0,0, 0));
        vecs.push_back(mk(1,0,11,1, 5,0, 0,0,0,  0,0,1,0,10, 1,4,0,0, 0));
        // full: a same-cycle commit does not let the request through
        vecs.push_back(mk(1,0,11,1, 1,0, 1,0,0,  0,0,1,0,10, 1,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  1,2, 1,1,0,  0,0,0,0,9,  0,0,1,1, 0));
        vecs.push_back(mk(1,0,11,1, 2,0, 0,0,0,  1,0,0,0,8,  0,0,0,0, 0));
        vecs.push_back(mk(1,0,12,1, 11,0, 0,0,0, 1,1,0,0,9,  1,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  12,3, 0,0,0, 0,2,1,0,10, 1,1,1,2, 0));
        vecs.push_back(mk(0,0,0,0,  3,0, 1,2,0,  0,2,1,0,10, 1,2,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  3,4, 1,3,0,  0,2,0,0,9,  0,0,1,3, 0));
        vecs.push_back(mk(0,0,0,0,  0,0, 1,4,0,  0,2,0,0,8,  0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  0,0, 1,5,0,  0,2,0,0,7,  0,0,0,0, 0));
        // nuke at count 6 with a request pending
        vecs.push_back(mk(1,0,13,1, 7,12, 0,0,1, 0,2,0,0,6,  1,6,1,1, 0));
        vecs.push_back(mk(0,0,0,0,  7,12, 0,0,0, 0,0,0,1,0,  0,0,0,0, 0));
        // build up, overlapping allocate and commit
        vecs.push_back(mk(1,0,1,1,  0,0, 0,0,0,  1,0,0,1,0,  0,0,0,0, 0));
        vecs.push_back(mk(1,0,2,1,  1,0, 0,0,0,  1,1,0,0,1,  1,0,0,0, 0));
        vecs.push_back(mk(1,0,3,1,  2,0, 0,0,0,  1,2,0,0,2,  1,1,0,0, 0));
        vecs.push_back(mk(1,0,4,1,  1,3, 1,0,0,  1,3,0,0,3,  1,0,1,2, 0));
        vecs.push_back(mk(1,0,5,1,  1,4, 1,1,0,  1,4,0,0,3,  0,0,1,3, 0));
        vecs.push_back(mk(1,0,6,1,  2,5, 0,0,0,  1,5,0,0,3,  0,0,1,4, 0));
        vecs.push_back(mk(1,0,8,1,  6,0, 0,0,0,  1,6,0,0,4,  1,5,0,0, 0));
        // re-allocate x3 while committing its older producer at tag 2
        vecs.push_back(mk(1,0,3,1,  3,8, 1,2,0,  1,7,0,0,5,  1,2,1,6, 0));
        vecs.push_back(mk(0,0,0,0,  3,0, 0,0,0,  0,8,0,0,5,  1,7,0,0, 0));
        // stall still lets the commit through
        vecs.push_back(mk(1,1,9,1,  4,0, 1,3,0,  0,8,0,0,5,  1,3,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  4,5, 0,0,1,  0,8,0,0,4,  0,0,1,4, 0));
        // re-definition of x7, x0 and non-writing allocations
        vecs.push_back(mk(1,0,0,1,  0,0, 0,0,0,  1,0,0,1,0,  0,0,0,0, 0));
        vecs.push_back(mk(1,0,7,1,  0,0, 0,0,0,  1,1,0,0,1,  0,0,0,0, 0));
        vecs.push_back(mk(1,0,9,0,  7,0, 0,0,0,  1,2,0,0,2,  1,1,0,0, 0));
        vecs.push_back(mk(1,0,10,1, 9,7, 0,0,0,  1,3,0,0,3,  0,0,1,1, 0));
        vecs.push_back(mk(1,0,7,1,  7,10, 0,0,0, 1,4,0,0,4,  1,1,1,3, 0));
        vecs.push_back(mk(0,0,0,0,  7,0, 1,0,0,  0,5,0,0,5,  1,4,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  7,0, 1,1,0,  0,5,0,0,4,  1,4,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  7,9, 1,2,0,  0,5,0,0,3,  1,4,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  10,7, 1,3,0, 0,5,0,0,2,  1,3,1,4, 0));
        vecs.push_back(mk(0,0,0,0,  7,0, 1,4,0,  0,5,0,0,1,  1,4,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  7,10, 0,0,0, 0,5,0,1,0,  0,0,0,0, 0));
        // protocol error: wrong index, then a nuke that must keep the flag
        vecs.push_back(mk(0,0,0,0,  0,0, 0,0,1,  0,5,0,1,0,  0,0,0,0, 0));
        vecs.push_back(mk(1,0,4,1,  0,0, 0,0,0,  1,0,0,1,0,  0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  4,0, 1,3,0,  0,1,0,0,1,  1,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,  4,0, 1,0,0,  0,1,0,0,1,  1,0,0,0, 1));
        vecs.push_back(mk(0,0,0,0,  4,0, 0,0,1,  0,1,0,1,0,  0,0,0,0, 1));
        vecs.push_back(mk(0,0,0,0,  0,0, 0,0,0,  0,0,0,1,0,  0,0,0,0, 1));

        drive(mk(0,0,0,0, 0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0, 0));
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(pack_exp(0,0,0,1,0, 0,0,0,0, 0));
        check("reset_state");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // asynchronous reset asserted mid-cycle clears the sticky flag at once
        @(posedge clk);
        #1;
        drive(mk(0,0,0,0, 0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0, 0));
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(pack_exp(0,0,0,1,0, 0,0,0,0, 0));
        check("async_reset_mid_cycle");
        @(negedge clk);
        #2;
        reset = 1'b1;

        // commit while empty
        apply(mk(0,0,0,0, 0,0, 1,0,0, 0,0,0,1,0, 0,0,0,0, 0), "commit_empty");
        apply(mk(0,0,0,0, 0,0, 0,0,0, 0,0,0,1,0, 0,0,0,0, 1), "err_after_empty_commit");

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
